// File: rtl/vr_msg_dispatch.sv
// Receive-side VR dispatcher: routes COMMIT and PREPARE messages to their engines.
// Stale-view and unknown messages are drained and counted.
module vr_msg_dispatch #(
    parameter int unsigned DATA_W       = 512,
    parameter int unsigned VIEW_W       = 64,
    parameter int unsigned OPNUM_W      = 64,
    parameter int unsigned CNT_W        = 32,
    parameter logic [7:0]  TYPE_PREPARE = 8'd1,
    parameter logic [7:0]  TYPE_COMMIT  = 8'd3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [VIEW_W-1:0]   cur_view,
    input  logic                in_hdr_val,
    output logic                in_hdr_rdy,
    input  logic [7:0]          in_hdr_msg_type,
    input  logic [VIEW_W-1:0]   in_hdr_view,
    input  logic [OPNUM_W-1:0]  in_hdr_opnum,
    input  logic                in_data_val,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_data_last,
    output logic                in_data_rdy,
    output logic                manage_commit_msg_val,
    output logic [VIEW_W-1:0]   manage_commit_view,
    output logic [OPNUM_W-1:0]  manage_commit_opnum,
    input  logic                commit_manage_msg_rdy,
    output logic                manage_commit_req_val,
    output logic                manage_commit_req_last,
    output logic [DATA_W-1:0]   manage_commit_data,
    input  logic                commit_manage_req_rdy,
    output logic                prep_hdr_val,
    output logic [VIEW_W-1:0]   prep_hdr_view,
    output logic [OPNUM_W-1:0]  prep_hdr_opnum,
    input  logic                prep_hdr_rdy,
    output logic                prep_data_val,
    output logic [DATA_W-1:0]   prep_data,
    output logic                prep_data_last,
    input  logic                prep_data_rdy,
    output logic [CNT_W-1:0]    commit_cnt,
    output logic [CNT_W-1:0]    prep_cnt,
    output logic [CNT_W-1:0]    drop_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        COMMIT_OUT,
        PREP_HDR,
        PREP_DATA,
        DRAIN
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [VIEW_W-1:0]   view_q;
    logic [OPNUM_W-1:0]  opnum_q;
    logic                hdr_take;
    logic                commit_inc;
    logic                prep_inc;
    logic                drop_inc;

    // Payload and latched header fields fan out to both engines; valids gate them.
    assign manage_commit_data     = in_data;
    assign manage_commit_req_last = in_data_last;
    assign prep_data              = in_data;
    assign prep_data_last         = in_data_last;
    assign manage_commit_view     = view_q;
    assign manage_commit_opnum    = opnum_q;
    assign prep_hdr_view          = view_q;
    assign prep_hdr_opnum         = opnum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Header fields only need to be valid while a message is in flight.
    always_ff @(posedge clk) begin
        if (hdr_take) begin
            view_q  <= in_hdr_view;
            opnum_q <= in_hdr_opnum;
        end
    end

    always_comb begin
        state_nxt             = state;
        in_hdr_rdy            = 1'b0;
        in_data_rdy           = 1'b0;
        manage_commit_msg_val = 1'b0;
        manage_commit_req_val = 1'b0;
        prep_hdr_val          = 1'b0;
        prep_data_val         = 1'b0;
        hdr_take              = 1'b0;
        commit_inc            = 1'b0;
        prep_inc              = 1'b0;
        drop_inc              = 1'b0;
        case (state)
            IDLE: begin
                in_hdr_rdy = 1'b1;
                if (in_hdr_val) begin
                    hdr_take = 1'b1;
                    if (in_hdr_view != cur_view) begin
                        state_nxt = DRAIN;
                        drop_inc  = 1'b1;
                    end else if (in_hdr_msg_type == TYPE_COMMIT) begin
                        state_nxt = COMMIT_OUT;
                    end else if (in_hdr_msg_type == TYPE_PREPARE) begin
                        state_nxt = PREP_HDR;
                    end else begin
                        state_nxt = DRAIN;
                        drop_inc  = 1'b1;
                    end
                end
            end
            COMMIT_OUT: begin
                // Commit engine takes header and first beat strictly as a pair.
                manage_commit_msg_val = in_data_val;
                manage_commit_req_val = in_data_val;
                in_data_rdy           = commit_manage_msg_rdy & commit_manage_req_rdy;
                if (in_data_val && in_data_rdy) begin
                    commit_inc = 1'b1;
                    state_nxt  = in_data_last ? IDLE : DRAIN;
                end
            end
            PREP_HDR: begin
                prep_hdr_val = 1'b1;
                if (prep_hdr_rdy) begin
                    prep_inc  = 1'b1;
                    state_nxt = PREP_DATA;
                end
            end
            PREP_DATA: begin
                prep_data_val = in_data_val;
                in_data_rdy   = prep_data_rdy;
                if (in_data_val && prep_data_rdy && in_data_last) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                in_data_rdy = 1'b1;
                if (in_data_val && in_data_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_cnt <= '0;
            prep_cnt   <= '0;
            drop_cnt   <= '0;
        end else begin
            if (commit_inc && (commit_cnt != '1)) commit_cnt <= commit_cnt + CNT_W'(1);
            if (prep_inc && (prep_cnt != '1))     prep_cnt   <= prep_cnt + CNT_W'(1);
            if (drop_inc && (drop_cnt != '1))     drop_cnt   <= drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vr_msg_dispatch.sv
// Directed bench for vr_msg_dispatch: table of single messages plus stall,
// reset-mid-message and counter saturation sequences (CNT_W=2).
module tb_vr_msg_dispatch;

    localparam int unsigned DATA_W  = 512;
    localparam int unsigned VIEW_W  = 64;
    localparam int unsigned OPNUM_W = 64;
    localparam int unsigned CNT_W   = 2;
    localparam int          BUDGET  = 200;

    logic                clk;
    logic                rst;
    logic [VIEW_W-1:0]   cur_view;
    logic                in_hdr_val;
    logic                in_hdr_rdy;
    logic [7:0]          in_hdr_msg_type;
    logic [VIEW_W-1:0]   in_hdr_view;
    logic [OPNUM_W-1:0]  in_hdr_opnum;
    logic                in_data_val;
    logic [DATA_W-1:0]   in_data;
    logic                in_data_last;
    logic                in_data_rdy;
    logic                manage_commit_msg_val;
    logic [VIEW_W-1:0]   manage_commit_view;
    logic [OPNUM_W-1:0]  manage_commit_opnum;
    logic                commit_manage_msg_rdy;
    logic                manage_commit_req_val;
    logic                manage_commit_req_last;
    logic [DATA_W-1:0]   manage_commit_data;
    logic                commit_manage_req_rdy;
    logic                prep_hdr_val;
    logic [VIEW_W-1:0]   prep_hdr_view;
    logic [OPNUM_W-1:0]  prep_hdr_opnum;
    logic                prep_hdr_rdy;
    logic                prep_data_val;
    logic [DATA_W-1:0]   prep_data;
    logic                prep_data_last;
    logic                prep_data_rdy;
    logic [CNT_W-1:0]    commit_cnt;
    logic [CNT_W-1:0]    prep_cnt;
    logic [CNT_W-1:0]    drop_cnt;

    vr_msg_dispatch #(
        .DATA_W(DATA_W), .VIEW_W(VIEW_W), .OPNUM_W(OPNUM_W), .CNT_W(CNT_W),
        .TYPE_PREPARE(8'd1), .TYPE_COMMIT(8'd3)
    ) dut (
        .clk(clk), .rst(rst), .cur_view(cur_view),
        .in_hdr_val(in_hdr_val), .in_hdr_rdy(in_hdr_rdy),
        .in_hdr_msg_type(in_hdr_msg_type), .in_hdr_view(in_hdr_view),
        .in_hdr_opnum(in_hdr_opnum),
        .in_data_val(in_data_val), .in_data(in_data), .in_data_last(in_data_last),
        .in_data_rdy(in_data_rdy),
        .manage_commit_msg_val(manage_commit_msg_val),
        .manage_commit_view(manage_commit_view),
        .manage_commit_opnum(manage_commit_opnum),
        .commit_manage_msg_rdy(commit_manage_msg_rdy),
        .manage_commit_req_val(manage_commit_req_val),
        .manage_commit_req_last(manage_commit_req_last),
        .manage_commit_data(manage_commit_data),
        .commit_manage_req_rdy(commit_manage_req_rdy),
        .prep_hdr_val(prep_hdr_val), .prep_hdr_view(prep_hdr_view),
        .prep_hdr_opnum(prep_hdr_opnum), .prep_hdr_rdy(prep_hdr_rdy),
        .prep_data_val(prep_data_val), .prep_data(prep_data),
        .prep_data_last(prep_data_last), .prep_data_rdy(prep_data_rdy),
        .commit_cnt(commit_cnt), .prep_cnt(prep_cnt), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  mtype;
        logic [63:0] view;
        logic [63:0] cview;
        logic [63:0] opnum;
        int          nbeats;
        bit          toggle;
        int          exp_commit_beats;
        int          exp_prep_beats;
        int          exp_commit_cnt;
        int          exp_prep_cnt;
        int          exp_drop_cnt;
    } vec_t;

    vec_t tbl[7];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] beat_val(input logic [63:0] op, input int b);
        logic [31:0] w;
        w = op[31:0] ^ (32'(b) << 24) ^ 32'h5A5A_0000;
        return {(DATA_W/32){w}};
    endfunction

    task automatic idle_inputs();
        in_hdr_val            = 1'b0;
        in_hdr_msg_type       = 8'd0;
        in_hdr_view           = '0;
        in_hdr_opnum          = '0;
        in_data_val           = 1'b0;
        in_data               = '0;
        in_data_last          = 1'b0;
        commit_manage_msg_rdy = 1'b1;
        commit_manage_req_rdy = 1'b1;
        prep_hdr_rdy          = 1'b1;
        prep_data_rdy         = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] t, input logic [63:0] v,
                            input logic [63:0] cv, input logic [63:0] op);
        @(negedge clk);
        cur_view        = cv;
        in_hdr_val      = 1'b1;
        in_hdr_msg_type = t;
        in_hdr_view     = v;
        in_hdr_opnum    = op;
        in_data_val     = 1'b0;
    endtask

    // Send one message with engines ready; observe routing, data order and counters.
    task automatic run_msg(input vec_t v, input string tag);
        int cb = 0, pb = 0, ph = 0, b = 0, cyc = 0;
        bit hdr_rdy_mid = 0;
        send_hdr(v.mtype, v.view, v.cview, v.opnum);
        #1 check({tag, " hdr_rdy"}, 64'(in_hdr_rdy), 64'(1));
        @(negedge clk);
        in_hdr_val = 1'b0;
        cur_view   = v.cview + 64'd7;
        while (b < v.nbeats && cyc < BUDGET) begin
            in_data_val   = 1'b1;
            in_data       = beat_val(v.opnum, b);
            in_data_last  = (b == v.nbeats - 1);
            prep_data_rdy = v.toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (in_hdr_rdy) hdr_rdy_mid = 1;
            if (prep_hdr_val && prep_hdr_rdy) begin
                ph++;
                check({tag, " prep_view"}, prep_hdr_view, v.view);
                check({tag, " prep_opnum"}, prep_hdr_opnum, v.opnum);
            end
            if (manage_commit_req_val && commit_manage_req_rdy && commit_manage_msg_rdy) begin
                cb++;
                check({tag, " cm_msg_val"}, 64'(manage_commit_msg_val), 64'(1));
                check({tag, " cm_opnum"}, manage_commit_opnum, v.opnum);
                check({tag, " cm_last"}, 64'(manage_commit_req_last), 64'(b == v.nbeats - 1));
                check_data({tag, " cm_data"}, manage_commit_data, beat_val(v.opnum, b));
            end
            if (prep_data_val && prep_data_rdy) begin
                pb++;
                check({tag, " pd_last"}, 64'(prep_data_last), 64'(b == v.nbeats - 1));
                check_data({tag, " pd_data"}, prep_data, beat_val(v.opnum, b));
            end
            if (in_data_rdy) b++;
            cyc++;
            @(negedge clk);
        end
        if (cyc >= BUDGET) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: beats=%0d required %0d", tag, b, v.nbeats);
        end
        in_data_val  = 1'b0;
        in_data_last = 1'b0;
        prep_data_rdy = 1'b1;
        #1;
        check({tag, " hdr_rdy_mid"}, 64'(hdr_rdy_mid), 64'(0));
        check({tag, " hdr_rdy_after"}, 64'(in_hdr_rdy), 64'(1));
        check({tag, " commit_beats"}, 64'(cb), 64'(v.exp_commit_beats));
        check({tag, " prep_beats"}, 64'(pb), 64'(v.exp_prep_beats));
        check({tag, " prep_hdrs"}, 64'(ph), 64'(v.exp_prep_beats != 0));
        check({tag, " commit_cnt"}, 64'(commit_cnt), 64'(v.exp_commit_cnt));
        check({tag, " prep_cnt"}, 64'(prep_cnt), 64'(v.exp_prep_cnt));
        check({tag, " drop_cnt"}, 64'(drop_cnt), 64'(v.exp_drop_cnt));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t sv;
        int   got;
        //             type   view    cur     opnum   n  tgl  cb pb cc pc dc
        tbl[0] = '{8'd3, 64'd5, 64'd5, 64'h10, 1, 1'b0, 1, 0, 1, 0, 0};
        tbl[1] = '{8'd1, 64'd5, 64'd5, 64'h11, 4, 1'b1, 0, 4, 0, 1, 0};
        tbl[2] = '{8'd1, 64'd4, 64'd5, 64'h12, 3, 1'b0, 0, 0, 0, 0, 1};
        tbl[3] = '{8'd9, 64'd5, 64'd5, 64'h13, 2, 1'b0, 0, 0, 0, 0, 1};
        tbl[4] = '{8'd3, 64'd5, 64'd5, 64'h14, 3, 1'b0, 1, 0, 1, 0, 0};
        tbl[5] = '{8'd3, 64'd6, 64'd5, 64'h15, 1, 1'b0, 0, 0, 0, 0, 1};
        tbl[6] = '{8'd1, 64'd5, 64'd5, 64'h16, 1, 1'b0, 0, 1, 0, 1, 0};

        rst      = 1'b1;
        cur_view = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_data_val = 1'b1;
        #1;
        check("reset cm_val", 64'(manage_commit_msg_val | manage_commit_req_val), 64'(0));
        check("reset prep_val", 64'(prep_hdr_val | prep_data_val), 64'(0));
        check("reset data_rdy", 64'(in_data_rdy), 64'(0));
        check("reset cnts", 64'({commit_cnt, prep_cnt, drop_cnt}), 64'(0));
        in_data_val = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_reset();
            run_msg(tbl[i], $sformatf("v%0d", i));
        end

        // COMMIT with both engine rdys held low for three cycles.
        do_reset();
        send_hdr(8'd3, 64'd5, 64'd5, 64'h10);
        @(negedge clk);
        in_hdr_val            = 1'b0;
        in_data_val           = 1'b1;
        in_data_last          = 1'b1;
        in_data               = beat_val(64'h10, 0);
        commit_manage_msg_rdy = 1'b0;
        commit_manage_req_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall msg_val", 64'(manage_commit_msg_val), 64'(1));
            check("stall req_val", 64'(manage_commit_req_val), 64'(1));
            check("stall data_rdy", 64'(in_data_rdy), 64'(0));
            check("stall view", manage_commit_view, 64'd5);
            check("stall opnum", manage_commit_opnum, 64'h10);
            check_data("stall data", manage_commit_data, beat_val(64'h10, 0));
            @(negedge clk);
        end
        commit_manage_msg_rdy = 1'b1;
        commit_manage_req_rdy = 1'b1;
        #1 check("stall release rdy", 64'(in_data_rdy), 64'(1));
        @(negedge clk);
        in_data_val  = 1'b0;
        in_data_last = 1'b0;
        #1;
        check("stall hdr_rdy", 64'(in_hdr_rdy), 64'(1));
        check("stall commit_cnt", 64'(commit_cnt), 64'(1));

        // Reset after beat 2 of a 4-beat PREPARE, then a fresh COMMIT.
        do_reset();
        send_hdr(8'd1, 64'd5, 64'd5, 64'h20);
        @(negedge clk);
        in_hdr_val = 1'b0;
        got = 0;
        for (int c = 0; c < BUDGET && got < 2; c++) begin
            in_data_val  = 1'b1;
            in_data      = beat_val(64'h20, got);
            in_data_last = 1'b0;
            #1;
            if (in_data_rdy) got++;
            @(negedge clk);
        end
        check("rstmid beats", 64'(got), 64'(2));
        check("rstmid prep_cnt pre", 64'(prep_cnt), 64'(1));
        rst = 1'b1;
        in_data = beat_val(64'h20, 2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid prep_val", 64'(prep_hdr_val | prep_data_val), 64'(0));
        check("rstmid cm_val", 64'(manage_commit_msg_val | manage_commit_req_val), 64'(0));
        check("rstmid cnts", 64'({commit_cnt, prep_cnt, drop_cnt}), 64'(0));
        check("rstmid hdr_rdy", 64'(in_hdr_rdy), 64'(1));
        in_data_val = 1'b0;
        sv = '{8'd3, 64'd7, 64'd7, 64'h21, 1, 1'b0, 1, 0, 1, 0, 0};
        run_msg(sv, "rstmid commit");

        // Five back-to-back COMMITs: 2-bit counter stops at 3.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            sv = '{8'd3, 64'd9, 64'd9, 64'(k + 48), 1, 1'b0, 1, 0, (k + 1 > 3) ? 3 : k + 1, 0, 0};
            run_msg(sv, $sformatf("sat%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
